// File: rtl/msg_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// msg_seq_ctrl_if
// Bundles every non-clock/reset signal of the message sequencer: the
// host-side buffer write and control port, the mux select/return path and
// the byte-sink valid/ready handshake.
//   slave  modport : the sequencer's view (msg_seq_ctrl)
//   master modport : the surrounding system's view (host, mux, byte sink)
// Signals:
//   wr_en/wr_addr/wr_sel : message buffer write port
//   len/start/abort      : message length, start request, cancel
//   mux_sel/mux_y        : select to the 26-to-1 mux and its data return
//   tx_data/tx_valid/tx_ready : byte sink handshake
//   busy/done/err        : status
// ---------------------------------------------------------------------------
interface msg_seq_ctrl_if #(
    parameter int AW     = 4,
    parameter int SEL_W  = 5,
    parameter int DATA_W = 8
);
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [SEL_W-1:0]  wr_sel;
    logic [AW:0]       len;
    logic              start;
    logic              abort;
    logic [SEL_W-1:0]  mux_sel;
    logic [DATA_W-1:0] mux_y;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;
    logic              done;
    logic              err;

    modport slave (
        input  wr_en, wr_addr, wr_sel, len, start, abort, mux_y, tx_ready,
        output mux_sel, tx_data, tx_valid, busy, done, err
    );

    modport master (
        output wr_en, wr_addr, wr_sel, len, start, abort, mux_y, tx_ready,
        input  mux_sel, tx_data, tx_valid, busy, done, err
    );
endinterface

// File: rtl/msg_seq_ctrl.sv
// ---------------------------------------------------------------------------
// msg_seq_ctrl
// Steps a 26-to-1 byte mux through a small programmable message of select
// indices and offers each selected byte, registered, to a downstream sink.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : msg_seq_ctrl_if.slave (buffer write, start/abort/len, mux
//           select/return, tx valid/ready, busy/done/err)
// Per byte: SELECT drives mux_sel for one cycle and captures mux_y into
// tx_data; SEND holds tx_data/tx_valid until the sink accepts.
// ---------------------------------------------------------------------------
module msg_seq_ctrl #(
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int SEL_W    = 5,
    parameter int DATA_W   = 8,
    parameter int LAST_SEL = 25
) (
    input  logic          clk,
    input  logic          reset,
    msg_seq_ctrl_if.slave bus
);

    localparam logic [AW:0]      DEPTH_L    = (AW+1)'(DEPTH);
    localparam logic [AW:0]      LEN_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0]    IDX_ZERO   = '0;
    localparam logic [AW-1:0]    IDX_ONE    = AW'(1);
    localparam logic [SEL_W-1:0] LAST_SEL_L = SEL_W'(LAST_SEL);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SELECT,
        S_SEND,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [SEL_W-1:0]  mux_sel_q;
    logic [DATA_W-1:0] tx_data_q;
    logic              tx_valid_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [AW-1:0]     idx_q;
    logic [AW:0]       len_q;

    // Message buffer; contents are deliberately not reset.
    logic [SEL_W-1:0]  buf_q [DEPTH];

    logic              wr_fire;
    logic              wr_bad;
    logic [SEL_W-1:0]  wr_val;
    logic [AW-1:0]     idx_inc;
    logic [AW:0]       last_idx;
    logic              is_last;

    // Host writes land only while idle so a running message never changes.
    assign wr_fire  = bus.wr_en && (state_q == S_IDLE);
    assign wr_bad   = bus.wr_sel > LAST_SEL_L;
    assign wr_val   = wr_bad ? '0 : bus.wr_sel;
    assign idx_inc  = idx_q + IDX_ONE;
    assign last_idx = len_q - LEN_ONE;
    assign is_last  = ({1'b0, idx_q} == last_idx);

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            buf_q[bus.wr_addr] <= wr_val;
        end
    end

    // The buffer read is registered straight into mux_sel_q on the edge that
    // enters SELECT, so mux_sel is stable for all of SELECT and SEND.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mux_sel_q  <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            idx_q      <= '0;
            len_q      <= '0;
        end else begin
            done_q <= 1'b0;
            if (wr_fire && wr_bad) begin
                err_q <= 1'b1;
            end

            // abort only matters once a message is running, which is also
            // why start wins when both arrive together in IDLE.
            if (bus.abort && (state_q != S_IDLE)) begin
                state_q    <= S_IDLE;
                tx_valid_q <= 1'b0;
                idx_q      <= '0;
                busy_q     <= 1'b0;
                mux_sel_q  <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.start && (bus.len != '0)) begin
                            len_q     <= (bus.len > DEPTH_L) ? DEPTH_L : bus.len;
                            idx_q     <= '0;
                            mux_sel_q <= buf_q[IDX_ZERO];
                            busy_q    <= 1'b1;
                            state_q   <= S_SELECT;
                        end
                    end
                    S_SELECT: begin
                        tx_data_q  <= bus.mux_y;
                        tx_valid_q <= 1'b1;
                        state_q    <= S_SEND;
                    end
                    S_SEND: begin
                        if (tx_valid_q && bus.tx_ready) begin
                            tx_valid_q <= 1'b0;
                            if (is_last) begin
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end else begin
                                idx_q     <= idx_inc;
                                mux_sel_q <= buf_q[idx_inc];
                                state_q   <= S_SELECT;
                            end
                        end
                    end
                    S_DONE: begin
                        busy_q    <= 1'b0;
                        idx_q     <= '0;
                        mux_sel_q <= '0;
                        state_q   <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.mux_sel  = mux_sel_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_msg_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_msg_seq_ctrl
// Directed bench for msg_seq_ctrl. The mux is modelled as x_i = 8'h41 + i.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_msg_seq_ctrl;

    logic clk = 1'b0;
    logic reset;

    msg_seq_ctrl_if #(.AW(4), .SEL_W(5), .DATA_W(8)) bus ();

    msg_seq_ctrl #(
        .DEPTH(16), .AW(4), .SEL_W(5), .DATA_W(8), .LAST_SEL(25)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.mux_y = 8'h41 + {3'b000, bus.mux_sel};

    int err_cnt = 0;
    int chk_cnt = 0;

    logic [7:0] got [$];
    logic [7:0] stall_vals [$];
    logic [7:0] exp_q [$];
    int         hs_cyc [$];
    int         done_cnt;
    int         done_cyc;
    int         end_cyc;
    int         valid_cnt;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_buf(input int a, input int s);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a[3:0];
        bus.wr_sel  = s[4:0];
        @(negedge clk);
        bus.wr_en   = 1'b0;
        $display("write buf[%0d] = %0d", a, s);
    endtask

    task automatic write_msg();
        write_buf(0, 7);
        write_buf(1, 4);
        write_buf(2, 11);
        write_buf(3, 11);
        write_buf(4, 14);
    endtask

    task automatic pulse_start(input int l);
        bus.len   = l[4:0];
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        $display("start len=%0d", l);
    endtask

    // Acts as the byte sink until busy drops or the cycle budget runs out.
    // stall_byte/stall_len: hold tx_ready low for that byte; kill_at: abort
    // (or reset) once that many bytes are taken; poke_at: pulse start and a
    // buffer write while busy once that many bytes are taken.
    task automatic collect(input int stall_byte, input int stall_len, input int kill_at,
                           input bit kill_rst, input int poke_at, input int max_cyc);
        int cyc = 0;
        int stall_left = stall_len;
        bit killed = 1'b0;
        bit poked = 1'b0;
        got.delete();
        hs_cyc.delete();
        stall_vals.delete();
        done_cnt  = 0;
        done_cyc  = -1;
        valid_cnt = 0;
        while (bus.busy === 1'b1 && cyc < max_cyc) begin
            bus.start = 1'b0;
            bus.wr_en = 1'b0;
            bus.abort = 1'b0;
            if (bus.done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (!killed && kill_at >= 0 && got.size() == kill_at) begin
                killed = 1'b1;
                if (kill_rst) reset = 1'b1;
                else          bus.abort = 1'b1;
            end
            if (!poked && poke_at >= 0 && got.size() == poke_at) begin
                poked       = 1'b1;
                bus.start   = 1'b1;
                bus.len     = 5'd5;
                bus.wr_en   = 1'b1;
                bus.wr_addr = 4'd3;
                bus.wr_sel  = 5'd0;
            end
            bus.tx_ready = 1'b1;
            if (bus.tx_valid === 1'b1) begin
                valid_cnt++;
                if (got.size() == stall_byte && stall_left > 0) begin
                    bus.tx_ready = 1'b0;
                    stall_left--;
                    stall_vals.push_back(bus.tx_data);
                end else begin
                    got.push_back(bus.tx_data);
                    hs_cyc.push_back(cyc);
                    $display("  byte %0d = %02h at cycle %0d", got.size() - 1, bus.tx_data, cyc);
                end
            end
            @(negedge clk);
            cyc++;
        end
        bus.start    = 1'b0;
        bus.wr_en    = 1'b0;
        bus.abort    = 1'b0;
        bus.tx_ready = 1'b1;
        end_cyc = cyc;
        check_eq("run_in_budget", 32'(cyc < max_cyc), 32'd1);
    endtask

    task automatic check_msg(input string tag);
        check_eq({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check_eq($sformatf("%s_byte%0d", tag, i),
                     (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_sel   = '0;
        bus.len      = '0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.tx_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_mux_sel",  bus.mux_sel,  0);
        check_eq("rst_tx_data",  bus.tx_data,  0);
        check_eq("rst_tx_valid", bus.tx_valid, 0);
        check_eq("rst_busy",     bus.busy,     0);
        check_eq("rst_done",     bus.done,     0);
        check_eq("rst_err",      bus.err,      0);
        reset = 1'b0;
        @(negedge clk);

        // 1: basic message, sink always ready
        $display("test 1: basic message");
        write_msg();
        pulse_start(5);
        check_eq("t1_select_mux_sel", bus.mux_sel, 7);
        check_eq("t1_select_valid",   bus.tx_valid, 0);
        check_eq("t1_select_busy",    bus.busy, 1);
        collect(-1, 0, -1, 1'b0, -1, 200);
        exp_q = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        check_msg("t1");
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("t1_hs_cycle%0d", i),
                     (i < hs_cyc.size()) ? 32'(hs_cyc[i]) : 32'hFFFF_FFFF, 32'(1 + 2 * i));
        end
        check_eq("t1_valid_cycles", valid_cnt, 5);
        check_eq("t1_done_count", done_cnt, 1);
        check_eq("t1_done_cycle", done_cyc, 10);
        check_eq("t1_busy_fall_cycle", end_cyc, 11);
        check_eq("t1_idle_mux_sel", bus.mux_sel, 0);

        // 2: sink stalls 5 cycles on byte 2
        $display("test 2: stalled sink");
        pulse_start(5);
        collect(1, 5, -1, 1'b0, -1, 200);
        check_msg("t2");
        check_eq("t2_stall_cycles", stall_vals.size(), 5);
        for (int i = 0; i < stall_vals.size(); i++) begin
            check_eq($sformatf("t2_stall_hold%0d", i), stall_vals[i], 8'h45);
        end
        check_eq("t2_valid_cycles", valid_cnt, 10);
        check_eq("t2_done_count", done_cnt, 1);

        // 3: len=0 ignored, then len=20 clamps to 16 bytes
        $display("test 3: len boundaries");
        begin
            logic seen = 1'b0;
            pulse_start(0);
            for (int i = 0; i < 4; i++) begin
                seen = seen | bus.busy | bus.tx_valid | bus.done;
                @(negedge clk);
            end
            check_eq("t3_len0_ignored", seen, 0);
        end
        for (int i = 0; i < 16; i++) write_buf(i, i);
        pulse_start(20);
        collect(-1, 0, -1, 1'b0, -1, 400);
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(8'h41 + 8'(i));
        check_msg("t3");
        check_eq("t3_done_count", done_cnt, 1);
        check_eq("t3_err_clear", bus.err, 0);

        // 4: illegal index stored as 0, err sticky
        $display("test 4: illegal index");
        write_buf(0, 30);
        check_eq("t4_err_set", bus.err, 1);
        pulse_start(1);
        collect(-1, 0, -1, 1'b0, -1, 200);
        exp_q = '{8'h41};
        check_msg("t4");
        check_eq("t4_done_count", done_cnt, 1);
        check_eq("t4_err_sticky", bus.err, 1);

        // 5: abort after byte 2, then reset after byte 2
        $display("test 5: abort and reset mid-message");
        write_msg();
        pulse_start(5);
        collect(-1, 0, 2, 1'b0, -1, 200);
        exp_q = '{8'h48, 8'h45};
        check_msg("t5a");
        check_eq("t5a_done_count", done_cnt, 0);
        check_eq("t5a_busy",     bus.busy, 0);
        check_eq("t5a_tx_valid", bus.tx_valid, 0);
        @(negedge clk);
        check_eq("t5a_no_done",  bus.done, 0);
        pulse_start(5);
        collect(-1, 0, 2, 1'b1, -1, 200);
        check_eq("t5r_mux_sel",  bus.mux_sel,  0);
        check_eq("t5r_tx_data",  bus.tx_data,  0);
        check_eq("t5r_tx_valid", bus.tx_valid, 0);
        check_eq("t5r_busy",     bus.busy,     0);
        check_eq("t5r_done",     bus.done,     0);
        check_eq("t5r_err",      bus.err,      0);
        reset = 1'b0;
        @(negedge clk);

        // 6: start and write while busy are ignored; idle writes take effect
        $display("test 6: writes while busy");
        write_msg();
        pulse_start(5);
        collect(-1, 0, -1, 1'b0, 1, 200);
        exp_q = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        check_msg("t6a");
        check_eq("t6a_done_count", done_cnt, 1);
        repeat (2) @(negedge clk);
        check_eq("t6a_no_restart", bus.busy, 0);
        pulse_start(5);
        collect(-1, 0, -1, 1'b0, -1, 200);
        check_msg("t6b");
        write_buf(3, 0);
        pulse_start(5);
        collect(-1, 0, -1, 1'b0, -1, 200);
        exp_q = '{8'h48, 8'h45, 8'h4C, 8'h41, 8'h4F};
        check_msg("t6c");

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
